// File: rtl/pll_reset_sequencer_pkg.sv
// rtl/pll_reset_sequencer_pkg.sv - shared state encoding and width helpers for the PLL reset sequencer
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  function automatic int unsigned cw(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - drives PLL RST, qualifies LOCK, releases the system reset
// Lock-wait timeout with retry counting is built only when PLL_SEQ_TIMEOUT_EN is defined.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned HOLD_CYCLES  = 256,
  parameter int unsigned LOCK_TIMEOUT = 480000,
  parameter int unsigned RETRY_W      = 4
) (
  input  logic               clkin,
  input  logic               reset_n,
  input  logic               locked,
  input  logic               restart,
  output logic               pll_reset,
  output logic               sys_reset_n,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic [1:0]         state
);

  localparam int unsigned CNT_W = cw(max3(RST_CYCLES, LOCK_STABLE, HOLD_CYCLES));

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               locked_s;
  logic               lock_lost_d;
  logic               pll_reset_q, sys_reset_n_q, ready_q, lock_lost_q;

  sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
    .clk_i  (clkin),
    .rst_ni (reset_n),
    .d_i    (locked),
    .q_o    (locked_s)
  );

`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = cw(LOCK_TIMEOUT);
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               tmo_fire;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    lock_lost_d = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
    tmo_fire    = 1'b0;
`endif
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (!locked_s) cnt_d = '0;
        else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) state_d = ST_HOLD;
`ifdef PLL_SEQ_TIMEOUT_EN
        if (state_d == ST_WAIT_LOCK && tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
          state_d  = ST_PLL_RST;
          tmo_fire = 1'b1;
        end
`endif
      end
      ST_HOLD: begin
        if (!locked_s) state_d = ST_PLL_RST;
        else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d     = ST_PLL_RST;
          lock_lost_d = 1'b1;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase
    // A restart overrides every other transition, including a coincident lock loss.
    if (restart) begin
      state_d     = ST_PLL_RST;
      lock_lost_d = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
      tmo_fire    = 1'b0;
`endif
    end
    if (restart || state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      state_q       <= ST_PLL_RST;
      cnt_q         <= '0;
      pll_reset_q   <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_reset_q   <= (state_d == ST_PLL_RST);
      sys_reset_n_q <= (state_d == ST_RUN);
      ready_q       <= (state_d == ST_RUN);
      lock_lost_q   <= lock_lost_d;
    end
  end

`ifdef PLL_SEQ_TIMEOUT_EN
  // The timeout spans the whole WAIT_LOCK visit, independent of stability-counter clears.
  always_comb begin
    tmo_d   = (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK) ? tmo_q + TMO_W'(1) : '0;
    retry_d = (tmo_fire && retry_q != {RETRY_W{1'b1}}) ? retry_q + RETRY_W'(1) : retry_q;
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      tmo_q   <= '0;
      retry_q <= '0;
    end else begin
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
    end
  end

  assign retry_count = retry_q;
`else
  logic unused_lock_timeout;
  assign unused_lock_timeout = ^LOCK_TIMEOUT;
  assign retry_count         = '0;
`endif

  assign pll_reset   = pll_reset_q;
  assign sys_reset_n = sys_reset_n_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign state       = state_q;

endmodule
